// File: rtl/proc_hs_pkg.sv
// Shared opcodes, FSM encoding and helpers for the handshake multicycle processor.
package proc_hs_pkg;

    localparam logic [3:0] OpLd   = 4'd0;
    localparam logic [3:0] OpSt   = 4'd1;
    localparam logic [3:0] OpMvnz = 4'd2;
    localparam logic [3:0] OpMv   = 4'd3;
    localparam logic [3:0] OpMvi  = 4'd4;
    localparam logic [3:0] OpAdd  = 4'd5;
    localparam logic [3:0] OpSub  = 4'd6;
    localparam logic [3:0] OpOr   = 4'd7;
    localparam logic [3:0] OpSlt  = 4'd8;
    localparam logic [3:0] OpSll  = 4'd9;
    localparam logic [3:0] OpSrl  = 4'd10;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StMemRd  = 3'd3,
        StMemWr  = 3'd4,
        StAlu    = 3'd5,
        StWb     = 3'd6
    } state_e;

    function automatic int unsigned proc_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/alu_param.sv
// Combinational ALU for the multicycle processor; shifts saturate to zero at or beyond the width.
module alu_param
    import proc_hs_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] result
);

    localparam logic [DATA_W-1:0] WidthVal = DATA_W'(DATA_W);

    logic shift_out;
    assign shift_out = (B >= WidthVal);

    always_comb begin
        result = '0;
        case (opcode)
            OpAdd:   result = A + B;
            OpSub:   result = A - B;
            OpOr:    result = A | B;
            OpSlt:   result = {{(DATA_W-1){1'b0}}, (A < B)};
            OpSll:   result = shift_out ? '0 : (A << B);
            OpSrl:   result = shift_out ? '0 : (A >> B);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/proc_multiciclo_hs.sv
// Parametrised multicycle processor with a MemReq/MemAck memory handshake.
// R[NREGS-1] is the PC; the FSM waits in FETCH/MEMRD/MEMWR until memory acknowledges.
module proc_multiciclo_hs
    import proc_hs_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       NREGS    = 8,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    input  logic              MemAck,
    output logic              MemReq,
    output logic              Write,
    output logic [DATA_W-1:0] AddressOut,
    output logic [DATA_W-1:0] DOUT,
    output logic [DATA_W-1:0] BusWires,
    output logic              Done,
    output logic              Illegal,
    output logic [2:0]        State
);

    localparam int unsigned RB = proc_clog2(NREGS);
    localparam int unsigned IW = 4 + 2 * RB;
    localparam logic [RB-1:0] PcIdx = RB'(NREGS - 1);

    state_e state_q, state_d;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] a_q, g_q;
    logic [IW-1:0]     ir_q;

    logic [3:0]        op;
    logic [RB-1:0]     rx, ry;
    logic [DATA_W-1:0] rx_val, ry_val, pc, alu_res;

    logic              rf_we, pc_inc, ir_we, a_we, g_we;
    logic [DATA_W-1:0] rf_wdata;
    state_e            retire_st;

    assign op     = ir_q[IW-1 -: 4];
    assign rx     = ir_q[2*RB-1 -: RB];
    assign ry     = ir_q[RB-1:0];
    assign rx_val = regs_q[rx];
    assign ry_val = regs_q[ry];
    assign pc     = regs_q[PcIdx];
    assign State  = state_q;

    assign retire_st = Run ? StFetch : StIdle;

    alu_param #(
        .DATA_W(DATA_W)
    ) u_alu (
        .opcode(op),
        .A     (a_q),
        .B     (ry_val),
        .result(alu_res)
    );

    always_comb begin
        state_d    = state_q;
        MemReq     = 1'b0;
        Write      = 1'b0;
        AddressOut = '0;
        DOUT       = '0;
        BusWires   = '0;
        Done       = 1'b0;
        Illegal    = 1'b0;
        rf_we      = 1'b0;
        rf_wdata   = '0;
        pc_inc     = 1'b0;
        ir_we      = 1'b0;
        a_we       = 1'b0;
        g_we       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Run) state_d = StFetch;
            end
            StFetch: begin
                MemReq     = 1'b1;
                AddressOut = pc;
                if (MemAck) begin
                    ir_we   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                case (op)
                    OpMv: begin
                        rf_we    = 1'b1;
                        rf_wdata = ry_val;
                        BusWires = ry_val;
                        Done     = 1'b1;
                        state_d  = retire_st;
                    end
                    OpMvnz: begin
                        if (g_q != '0) begin
                            rf_we    = 1'b1;
                            rf_wdata = ry_val;
                            BusWires = ry_val;
                        end
                        Done    = 1'b1;
                        state_d = retire_st;
                    end
                    OpLd, OpMvi: state_d = StMemRd;
                    OpSt:        state_d = StMemWr;
                    OpAdd, OpSub, OpOr, OpSlt, OpSll, OpSrl: begin
                        a_we    = 1'b1;
                        state_d = StAlu;
                    end
                    default: begin
                        Illegal = 1'b1;
                        Done    = 1'b1;
                        state_d = retire_st;
                    end
                endcase
            end
            StMemRd: begin
                MemReq     = 1'b1;
                AddressOut = (op == OpMvi) ? pc : ry_val;
                if (MemAck) begin
                    rf_we    = 1'b1;
                    rf_wdata = DIN;
                    BusWires = DIN;
                    // mvi steps past its immediate; a write to the PC itself still wins.
                    pc_inc   = (op == OpMvi);
                    Done     = 1'b1;
                    state_d  = retire_st;
                end
            end
            StMemWr: begin
                MemReq     = 1'b1;
                Write      = 1'b1;
                AddressOut = ry_val;
                DOUT       = rx_val;
                BusWires   = rx_val;
                if (MemAck) begin
                    Done    = 1'b1;
                    state_d = retire_st;
                end
            end
            StAlu: begin
                g_we    = 1'b1;
                state_d = StWb;
            end
            StWb: begin
                rf_we    = 1'b1;
                rf_wdata = g_q;
                BusWires = g_q;
                Done     = 1'b1;
                state_d  = retire_st;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[PcIdx] <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (ir_we) ir_q <= DIN[IW-1:0];
            if (a_we)  a_q  <= rx_val;
            if (g_we)  g_q  <= alu_res;
            if (pc_inc) regs_q[PcIdx] <= pc + DATA_W'(1);
            // Later assignment gives R[X] priority over the PC increment.
            if (rf_we) regs_q[rx] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_proc_multiciclo_hs.sv
// Self-checking bench: program table, handshake/reset corner cases, random run against an ISA model.
module tb_proc_multiciclo_hs;

    logic        Clock, Resetn, Run, MemAck, MemReq, Write, Done, Illegal;
    logic [15:0] DIN, AddressOut, DOUT, BusWires;
    logic [2:0]  State;

    proc_multiciclo_hs #(
        .DATA_W  (16),
        .NREGS   (8),
        .RESET_PC(16'h0000)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Run       (Run),
        .DIN       (DIN),
        .MemAck    (MemAck),
        .MemReq    (MemReq),
        .Write     (Write),
        .AddressOut(AddressOut),
        .DOUT      (DOUT),
        .BusWires  (BusWires),
        .Done      (Done),
        .Illegal   (Illegal),
        .State     (State)
    );

    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_res;

    alu_param #(
        .DATA_W(32)
    ) u_alu32 (
        .opcode(alu_op),
        .A     (alu_a),
        .B     (alu_b),
        .result(alu_res)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        logic [15:0] ins;
        logic [15:0] imm;
        bit          has_imm;
        int          w;
        int          lat;
        int          r;
        logic [15:0] val;
        int          ill;
    } vec_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    int n_pass = 0;
    int n_total = 0;

    logic [15:0] mem   [65536];
    logic [15:0] m_mem [65536];
    logic [15:0] m_r   [8];
    logic [15:0] m_g;

    int ws = 0;
    int wcnt = 0;
    bit spurious = 0;

    bit          o_done, o_ill, o_req;
    logic [2:0]  o_state;
    logic [15:0] o_addr, fetch_addr;
    int          memwr_n, memwr_bad;
    logic [15:0] wr_addr_exp, wr_data_exp;

    function automatic logic [15:0] enc(input int op, input int x, input int y);
        return 16'((op << 6) | (x << 3) | y);
    endfunction

    function automatic vec_t mk(input logic [15:0] ins, input logic [15:0] imm, input bit has_imm,
                                input int w, input int lat, input int r, input logic [15:0] val,
                                input int ill);
        vec_t v;
        v.ins = ins; v.imm = imm; v.has_imm = has_imm; v.w = w;
        v.lat = lat; v.r = r; v.val = val; v.ill = ill;
        return v;
    endfunction

    function automatic alu_vec_t mka(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] exp);
        alu_vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: memory responds after ws wait cycles, outputs sampled before the edge.
    task automatic tick();
        if (MemReq) begin
            DIN    = mem[AddressOut];
            MemAck = (wcnt >= ws);
        end else begin
            DIN    = '0;
            MemAck = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        #1;
        o_done  = Done;
        o_ill   = Illegal;
        o_req   = MemReq;
        o_state = State;
        o_addr  = AddressOut;
        if (State == 3'd4) begin
            memwr_n++;
            if (!(MemReq && Write && AddressOut == wr_addr_exp && DOUT == wr_data_exp))
                memwr_bad++;
        end
        if (MemReq && Write && MemAck) mem[AddressOut] = DOUT;
        wcnt = (MemReq && !MemAck) ? wcnt + 1 : 0;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_instr(output int lat, output int illc);
        int n;
        bit started;
        n = 0; started = 0; lat = -1; illc = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (!started && o_state == 3'd1) begin
                started    = 1;
                fetch_addr = o_addr;
            end
            if (started) begin
                n++;
                if (o_ill) illc++;
                if (o_done) begin
                    lat = n;
                    break;
                end
            end
        end
    endtask

    task automatic do_reset();
        Resetn = 1'b0; Run = 1'b0; MemAck = 1'b0; DIN = '0; wcnt = 0;
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
    endtask

    // ISA-level reference: executes one instruction, returns expected latency and illegal flag.
    task automatic model_step(input int w, output int lat, output int ill);
        logic [15:0] ins, a, b, res;
        logic [3:0]  op;
        logic [2:0]  x, y;
        ins = m_mem[m_r[7]];
        m_r[7] = m_r[7] + 16'd1;
        op = ins[9:6]; x = ins[5:3]; y = ins[2:0];
        ill = 0;
        lat = 2 + w;
        case (op)
            4'd0: begin m_r[x] = m_mem[m_r[y]]; lat = 3 + 2 * w; end
            4'd1: begin m_mem[m_r[y]] = m_r[x]; lat = 3 + 2 * w; end
            4'd2: if (m_g != 0) m_r[x] = m_r[y];
            4'd3: m_r[x] = m_r[y];
            4'd4: begin
                res = m_mem[m_r[7]];
                m_r[7] = m_r[7] + 16'd1;
                m_r[x] = res;
                lat = 3 + 2 * w;
            end
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
                a = m_r[x]; b = m_r[y];
                case (op)
                    4'd5:    res = a + b;
                    4'd6:    res = a - b;
                    4'd7:    res = a | b;
                    4'd8:    res = (a < b) ? 16'd1 : 16'd0;
                    4'd9:    res = (b >= 16) ? 16'd0 : a << b;
                    default: res = (b >= 16) ? 16'd0 : a >> b;
                endcase
                m_g = res;
                m_r[x] = res;
                lat = 4 + w;
            end
            default: ill = 1;
        endcase
    endtask

    vec_t     prog [16];
    alu_vec_t atab [9];

    initial begin
        int lat, illc, elat, eill, p;
        bit found;

        prog[0]  = mk(enc(4, 0, 0), 16'h0005, 1, 0, 3, 0, 16'h0005, 0);
        prog[1]  = mk(enc(4, 1, 0), 16'h0003, 1, 0, 3, 1, 16'h0003, 0);
        prog[2]  = mk(enc(5, 0, 1), 16'h0000, 0, 0, 4, 0, 16'h0008, 0);
        prog[3]  = mk(enc(6, 1, 0), 16'h0000, 0, 0, 4, 1, 16'hFFFB, 0);
        prog[4]  = mk(enc(4, 2, 0), 16'hABCD, 1, 0, 3, 2, 16'hABCD, 0);
        prog[5]  = mk(enc(4, 3, 0), 16'h0100, 1, 0, 3, 3, 16'h0100, 0);
        prog[6]  = mk(enc(1, 2, 3), 16'h0000, 0, 3, 9, 2, 16'hABCD, 0);
        prog[7]  = mk(enc(4, 4, 0), 16'h1111, 1, 0, 3, 4, 16'h1111, 0);
        prog[8]  = mk(enc(4, 5, 0), 16'h2222, 1, 0, 3, 5, 16'h2222, 0);
        prog[9]  = mk(enc(6, 6, 6), 16'h0000, 0, 0, 4, 6, 16'h0000, 0);
        prog[10] = mk(enc(2, 4, 5), 16'h0000, 0, 0, 2, 4, 16'h1111, 0);
        prog[11] = mk(enc(8, 6, 0), 16'h0000, 0, 0, 4, 6, 16'h0001, 0);
        prog[12] = mk(enc(2, 4, 5), 16'h0000, 0, 0, 2, 4, 16'h2222, 0);
        prog[13] = mk(16'h03C0,     16'h0000, 0, 0, 2, 7, 16'h0014, 1);
        prog[14] = mk(enc(0, 1, 3), 16'h0000, 0, 0, 3, 1, 16'hABCD, 0);
        prog[15] = mk(enc(3, 7, 0), 16'h0000, 0, 0, 2, 7, 16'h0008, 0);

        atab[0] = mka(4'd5,  32'hFFFF_FFFF, 32'h1,         32'h0);
        atab[1] = mka(4'd6,  32'h0,         32'h1,         32'hFFFF_FFFF);
        atab[2] = mka(4'd7,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
        atab[3] = mka(4'd8,  32'h1,         32'h2,         32'h1);
        atab[4] = mka(4'd8,  32'hFFFF_FFFF, 32'h1,         32'h0);
        atab[5] = mka(4'd9,  32'h1,         32'd40,        32'h0);
        atab[6] = mka(4'd9,  32'h1,         32'd31,        32'h8000_0000);
        atab[7] = mka(4'd10, 32'h8000_0000, 32'd31,        32'h1);
        atab[8] = mka(4'd10, 32'hFFFF_FFFF, 32'd32,        32'h0);

        // Reset state, checked while reset is still asserted.
        Resetn = 1'b0; Run = 1'b0; MemAck = 1'b0; DIN = '0;
        #2;
        chk("reset State", 32'(State), 32'd0);
        chk("reset MemReq", 32'(MemReq), 32'd0);
        chk("reset Write", 32'(Write), 32'd0);
        chk("reset Done", 32'(Done), 32'd0);
        chk("reset Illegal", 32'(Illegal), 32'd0);
        chk("reset PC", 32'(dut.regs_q[7]), 32'h0);
        chk("reset R0", 32'(dut.regs_q[0]), 32'h0);
        do_reset();

        for (int i = 0; i < 3; i++) tick();
        chk("idle without Run State", 32'(o_state), 32'd0);
        chk("idle without Run MemReq", 32'(o_req), 32'd0);

        for (int i = 0; i < 65536; i++) mem[i] = '0;
        p = 0;
        for (int i = 0; i < 16; i++) begin
            mem[p] = prog[i].ins;
            p++;
            if (prog[i].has_imm) begin
                mem[p] = prog[i].imm;
                p++;
            end
        end
        wr_addr_exp = 16'h0100; wr_data_exp = 16'hABCD;
        memwr_n = 0; memwr_bad = 0;

        Run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ws = prog[i].w;
            do_instr(lat, illc);
            if (i == 0) chk("first fetch address", 32'(fetch_addr), 32'h0);
            chk($sformatf("prog[%0d] latency", i), 32'(lat), 32'(prog[i].lat));
            chk($sformatf("prog[%0d] illegal", i), 32'(illc), 32'(prog[i].ill));
            chk($sformatf("prog[%0d] R%0d", i, prog[i].r), 32'(dut.regs_q[prog[i].r]),
                32'(prog[i].val));
        end
        ws = 0;
        chk("st cycles in MEMWR", 32'(memwr_n), 32'd4);
        chk("st MEMWR outputs unstable", 32'(memwr_bad), 32'd0);
        chk("st memory content", 32'(mem[16'h0100]), 32'hABCD);

        // Jump target used by next fetch; Run low at retirement parks the FSM in IDLE.
        Run = 1'b0;
        do_instr(lat, illc);
        chk("fetch after jump", 32'(fetch_addr), 32'h8);
        chk("mvi after jump R3", 32'(dut.regs_q[3]), 32'h0100);
        tick();
        tick();
        chk("Run low -> IDLE State", 32'(o_state), 32'd0);
        chk("Run low -> IDLE MemReq", 32'(o_req), 32'd0);

        // Reset pulsed during a stalled MEMRD.
        mem[10] = enc(0, 5, 3);
        ws = 10;
        Run = 1'b1;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_state == 3'd3) begin
                found = 1;
                break;
            end
        end
        chk("reached MEMRD", 32'(found), 32'd1);
        tick();
        tick();
        Resetn = 1'b0;
        #1;
        chk("async reset MemReq", 32'(MemReq), 32'd0);
        chk("async reset State", 32'(State), 32'd0);
        chk("async reset PC", 32'(dut.regs_q[7]), 32'h0);
        chk("async reset R5", 32'(dut.regs_q[5]), 32'h0);
        ws = 0;
        do_reset();

        // Random program from random memory against the ISA model.
        for (int i = 0; i < 65536; i++) begin
            mem[i]   = 16'($urandom);
            m_mem[i] = mem[i];
        end
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_g = '0;
        spurious = 1;
        Run = 1'b1;
        for (int k = 0; k < 200; k++) begin
            ws = $urandom_range(0, 2);
            model_step(ws, elat, eill);
            do_instr(lat, illc);
            chk($sformatf("rnd[%0d] latency", k), 32'(lat), 32'(elat));
            chk($sformatf("rnd[%0d] illegal", k), 32'(illc), 32'(eill));
            for (int r = 0; r < 8; r++) begin
                chk($sformatf("rnd[%0d] R%0d", k, r), 32'(dut.regs_q[r]), 32'(m_r[r]));
            end
        end
        spurious = 0;
        Run = 1'b0;

        for (int i = 0; i < 9; i++) begin
            alu_op = atab[i].op;
            alu_a  = atab[i].a;
            alu_b  = atab[i].b;
            #1;
            chk($sformatf("alu32[%0d]", i), alu_res, atab[i].exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
